// File: rtl/adder_pkg.sv
// ----------------------------------------------------------------------------
// adder_pkg
//   Shared definitions for the bit-serial adder family.
//   - state_t   : control FSM encoding (IDLE / SHIFT / DONE)
//   - MAX_WIDTH : largest operand width the serial adder is built for
// ----------------------------------------------------------------------------
package adder_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam int MAX_WIDTH = 32;

endpackage

// File: rtl/full_adder.sv
// ----------------------------------------------------------------------------
// full_adder
//   Single-bit full adder cell.
//   Ports:
//     sum  (out) : a ^ b ^ c
//     cout (out) : majority(a, b, c)
//     a, b (in)  : operand bits
//     c    (in)  : carry-in bit
// ----------------------------------------------------------------------------
module full_adder (
   output logic sum,
   output logic cout,
   input  logic a,
   input  logic b,
   input  logic c
);

   assign sum  = a ^ b ^ c;
   assign cout = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/serial_adder.sv
// ----------------------------------------------------------------------------
// serial_adder
//   Bit-serial WIDTH-bit adder: {cout,sum} = a + b + cin, computed LSB first
//   over WIDTH clock cycles with one full_adder cell and a carry flop.
//   Ports:
//     clk   (in)        : rising-edge clock
//     rst   (in)        : asynchronous active-high reset
//     start (in)        : request, sampled only while idle
//     a, b  (in, WIDTH) : operands, captured on the accepting edge
//     cin   (in)        : carry-in, captured on the accepting edge
//     busy  (out)       : a request is in progress
//     done  (out)       : one-cycle completion pulse
//     sum   (out, WIDTH): result of the last completed addition
//     cout  (out)       : carry-out of the last completed addition
// ----------------------------------------------------------------------------
module serial_adder
   import adder_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   // Counter must hold WIDTH without wrapping after the last shift edge.
   localparam int             CW   = $clog2(WIDTH + 1);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] psum_q, psum_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             carry_q, carry_d;
   logic             cout_q, cout_d;
   logic             done_q, done_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic             fa_sum;
   logic             fa_cout;

   full_adder u_fa (
      .sum  (fa_sum),
      .cout (fa_cout),
      .a    (a_q[0]),
      .b    (b_q[0]),
      .c    (carry_q)
   );

   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      psum_d  = psum_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      cnt_d   = cnt_q;
      done_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               a_d     = a;
               b_d     = b;
               carry_d = cin;
               psum_d  = '0;
               cnt_d   = '0;
               state_d = SHIFT;
            end
         end

         SHIFT: begin
            // Result bits enter at the MSB so that after WIDTH shifts the
            // first (LSB) result bit has reached bit 0.
            psum_d         = psum_q >> 1;
            psum_d[WIDTH-1] = fa_sum;
            a_d            = a_q >> 1;
            b_d            = b_q >> 1;
            carry_d        = fa_cout;
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
               // Publish the fully assembled result only here, so sum/cout
               // never show partial values.
               sum_d   = psum_d;
               cout_d  = fa_cout;
               done_d  = 1'b1;
               state_d = DONE;
            end
         end

         DONE: begin
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         a_q     <= '0;
         b_q     <= '0;
         psum_q  <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         done_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         psum_q  <= psum_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         done_q  <= done_d;
         cnt_q   <= cnt_d;
      end
   end

   assign busy = (state_q != IDLE);
   assign done = done_q;
   assign sum  = sum_q;
   assign cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
module tb_serial_adder;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks   = 0;
   int failures = 0;

   // ---------------- WIDTH=8 instance ----------------
   logic       start8, cin8, busy8, done8, cout8;
   logic [7:0] a8, b8, sum8;
   int         done8_cnt = 0;
   always @(negedge clk) if (done8) done8_cnt <= done8_cnt + 1;

   serial_adder #(.WIDTH(8)) u_w8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
      .busy(busy8), .done(done8), .sum(sum8), .cout(cout8)
   );

   // ---------------- WIDTH=4 instance ----------------
   logic       start4, cin4, busy4, done4, cout4;
   logic [3:0] a4, b4, sum4;

   serial_adder #(.WIDTH(4)) u_w4 (
      .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
      .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
   );

   // ---------------- WIDTH=1 instance ----------------
   logic start1, cin1, busy1, done1, cout1;
   logic a1, b1, sum1;

   serial_adder #(.WIDTH(1)) u_w1 (
      .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1),
      .busy(busy1), .done(done1), .sum(sum1), .cout(cout1)
   );

   typedef struct {
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] sum;
      logic       cout;
   } vec_t;

   vec_t tbl[6];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // One WIDTH=8 transaction. mutate: clear inputs right after accept.
   // poke: pulse start (with other operands) while the addition runs.
   task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] exp_sum, input logic exp_cout,
                      input bit mutate, input bit poke, input string tag);
      int   n;
      int   d0;
      bit   stable;
      bit   busy_ok;
      logic [8:0] prev;
      prev    = {cout8, sum8};
      stable  = 1'b1;
      busy_ok = 1'b1;
      @(negedge clk);
      a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
      @(posedge clk); #1;
      chk({tag, " busy_at_accept"}, busy8, 1);
      @(negedge clk);
      start8 = 1'b0;
      d0 = done8_cnt;
      if (mutate) begin a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; end
      for (n = 1; n <= 12; n++) begin
         @(posedge clk); #1;
         if (done8) break;
         if (!busy8) busy_ok = 1'b0;
         if ({cout8, sum8} !== prev) stable = 1'b0;
         if (poke && n == 2) begin @(negedge clk); start8 = 1'b1; a8 = 8'h01; b8 = 8'h01; end
         if (poke && n == 3) begin @(negedge clk); start8 = 1'b0; end
      end
      chk({tag, " latency"}, n, 8);
      chk({tag, " busy_during_shift"}, busy_ok, 1);
      chk({tag, " no_intermediate"}, stable, 1);
      chk({tag, " sum"}, sum8, exp_sum);
      chk({tag, " cout"}, cout8, exp_cout);
      chk({tag, " busy_in_done"}, busy8, 1);
      @(posedge clk); #1;
      chk({tag, " done_one_cycle"}, done8, 0);
      chk({tag, " busy_after"}, busy8, 0);
      if (poke) begin
         repeat (14) @(posedge clk);
         #1;
         chk({tag, " single_done"}, done8_cnt - d0, 1);
         chk({tag, " idle_after_poke"}, busy8, 0);
         chk({tag, " sum_kept"}, sum8, exp_sum);
      end
   endtask

   initial begin
      int         n;
      int         d0;
      int         t_first;
      int         t_second;
      int         last_done;
      bit         ok;
      logic [8:0] m;
      logic [7:0] ra, rb;
      logic       rc;

      tbl[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
      tbl[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0};
      tbl[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
      tbl[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
      tbl[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
      tbl[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};

      rst = 1'b1;
      start8 = 0; a8 = 0; b8 = 0; cin8 = 0;
      start4 = 0; a4 = 0; b4 = 0; cin4 = 0;
      start1 = 0; a1 = 0; b1 = 0; cin1 = 0;
      repeat (2) @(negedge clk);
      chk("reset busy", busy8, 0);
      chk("reset done", done8, 0);
      chk("reset sum", sum8, 0);
      chk("reset cout", cout8, 0);
      rst = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 6; i++)
         op8(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sum, tbl[i].cout, 1'b0, 1'b0,
             $sformatf("tbl%0d", i));

      // Asynchronous reset in the middle of SHIFT
      @(negedge clk);
      a8 = 8'hAA; b8 = 8'h55; cin8 = 1'b0; start8 = 1'b1;
      @(posedge clk);
      @(negedge clk); start8 = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      chk("async_rst busy", busy8, 0);
      chk("async_rst done", done8, 0);
      chk("async_rst sum", sum8, 0);
      chk("async_rst cout", cout8, 0);
      @(negedge clk); rst = 1'b0;
      d0 = done8_cnt;
      repeat (15) @(posedge clk);
      #1;
      chk("after_rst no_done", done8_cnt - d0, 0);
      chk("after_rst idle", busy8, 0);
      chk("after_rst sum", sum8, 0);

      // Inputs changing after accept must not matter
      op8(8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1, 1'b0, "mutate");

      // start pulsed during SHIFT is ignored
      op8(8'h21, 8'h43, 1'b0, 8'h64, 1'b0, 1'b0, 1'b1, "poke");

      // Held start: two results 10 cycles apart
      @(negedge clk);
      a8 = 8'h10; b8 = 8'h20; cin8 = 1'b0; start8 = 1'b1;
      t_first = -1; t_second = -1;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); #1;
         if (done8) begin
            if (t_first < 0) begin
               t_first = cyc;
               chk("held first sum", {cout8, sum8}, 9'h030);
               @(negedge clk);
               a8 = 8'h33; b8 = 8'h44;
            end else begin
               t_second = cyc;
               chk("held second sum", {cout8, sum8}, 9'h077);
               @(negedge clk);
               start8 = 1'b0;
               break;
            end
         end
      end
      chk("held spacing", t_second - t_first, 10);
      repeat (3) @(posedge clk);

      // Randomised against the arithmetic model
      for (int i = 0; i < 20; i++) begin
         ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
         m  = 9'(ra) + 9'(rb) + 9'(rc);
         op8(ra, rb, rc, m[7:0], m[8], 1'b0, 1'b0, $sformatf("rnd%0d", i));
      end

      // Exhaustive WIDTH=4 under continuous start
      last_done = 0;
      for (int i = 0; i < 512; i++) begin
         logic [3:0] ea, eb;
         logic       ec;
         logic [4:0] er;
         {ec, ea, eb} = 9'(i);
         er = 5'(ea) + 5'(eb) + 5'(ec);
         ok = 1'b0;
         for (int w = 0; w < 20; w++) begin
            @(negedge clk);
            if (!busy4) begin ok = 1'b1; break; end
         end
         if (!ok) chk("w4 idle_timeout", 0, 1);
         a4 = ea; b4 = eb; cin4 = ec; start4 = 1'b1;
         @(posedge clk);
         for (n = 1; n <= 10; n++) begin
            @(posedge clk); #1;
            if (done4) break;
         end
         chk($sformatf("w4 latency %0d", i), n, 4);
         chk($sformatf("w4 result %0d", i), {cout4, sum4}, er);
         if (i > 0) chk($sformatf("w4 spacing %0d", i), cyc - last_done, 6);
         last_done = cyc;
      end
      @(negedge clk); start4 = 1'b0;

      // WIDTH=1: all eight single-bit cases
      for (int i = 7; i >= 0; i--) begin
         logic [1:0] er1;
         logic [2:0] iv;
         iv = 3'(i);
         er1 = 2'(iv[2]) + 2'(iv[1]) + 2'(iv[0]);
         @(negedge clk);
         a1 = iv[2]; b1 = iv[1]; cin1 = iv[0]; start1 = 1'b1;
         @(posedge clk);
         @(negedge clk); start1 = 1'b0;
         for (n = 1; n <= 6; n++) begin
            @(posedge clk); #1;
            if (done1) break;
         end
         chk($sformatf("w1 latency %0d", i), n, 1);
         chk($sformatf("w1 result %0d", i), {cout1, sum1}, er1);
         repeat (2) @(posedge clk);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
